// File: rtl/pico_bus_decoder.sv
// pico_bus_decoder
// Address decoder and response sequencer between the PicoRV32 native memory
// port and its slaves (on-chip RAM and the LED register). Each request is
// decoded once in IDLE. The slave choice and the request itself are held in
// registers, so the selects are glitch-free. A cycle budget bounds every
// access. Unmapped or hung accesses return ERR_DATA and raise a sticky bus
// error, so the core can never stall forever.

module pico_bus_decoder #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] LEDS_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        ram_sel,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        leds_sel,
    input  logic        leds_ready,
    input  logic [31:0] leds_rdata,
    output logic        slv_we,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    input  logic        bus_err_clr,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SLV_NONE = 2'd0,
        SLV_RAM  = 2'd1,
        SLV_LEDS = 2'd2
    } slave_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state_q,     state_d;
    slave_t      slave_q,     slave_d;
    logic [31:0] reqAddr_q,   reqAddr_d;
    logic [31:0] reqWdata_q,  reqWdata_d;
    logic [3:0]  reqWstrb_q,  reqWstrb_d;
    logic [15:0] waitCnt_q,   waitCnt_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        busErr_q,    busErr_d;
    logic [31:0] errAddr_q,   errAddr_d;

    logic        hitRam;
    logic        hitLeds;
    logic        slaveReady;
    logic [31:0] slaveRdata;
    logic        errSet;

    // Address decode of the live request. RAM is checked first, so an
    // overlapping LED address inside the RAM window resolves to RAM.
    always_comb begin
        hitRam  = (mem_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
        hitLeds = (mem_addr[31:2] == LEDS_ADDR[31:2]);
    end

    // Slave selects and write-side signals come only from registered state,
    // so they cannot glitch and they are never high outside ACCESS.
    always_comb begin
        ram_sel   = (state_q == ACCESS) && (slave_q == SLV_RAM);
        leds_sel  = (state_q == ACCESS) && (slave_q == SLV_LEDS);
        slv_we    = (state_q == ACCESS) && (reqWstrb_q != 4'b0000);
        slv_wdata = reqWdata_q;
        slv_wstrb = reqWstrb_q;
        mem_ready = (state_q == RESP);
        mem_rdata = rdata_q;
        bus_err   = busErr_q;
        err_addr  = errAddr_q;
    end

    // Return path from the currently selected slave. The ready of an
    // unselected slave never reaches the sequencer.
    always_comb begin
        slaveReady = 1'b0;
        slaveRdata = 32'h0;
        if (ram_sel) begin
            slaveReady = ram_ready;
            slaveRdata = ram_rdata;
        end else if (leds_sel) begin
            slaveReady = leds_ready;
            slaveRdata = leds_rdata;
        end
    end

    // Next-state and datapath logic for the IDLE -> ACCESS -> RESP sequence,
    // including the wait-cycle budget and the sticky error bookkeeping.
    always_comb begin
        state_d    = state_q;
        slave_d    = slave_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        reqWstrb_d = reqWstrb_q;
        waitCnt_d  = waitCnt_q;
        rdata_d    = rdata_q;
        busErr_d   = busErr_q;
        errAddr_d  = errAddr_q;
        errSet     = 1'b0;

        if (bus_err_clr) begin
            busErr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    reqAddr_d  = mem_addr;
                    reqWdata_d = mem_wdata;
                    reqWstrb_d = mem_wstrb;
                    waitCnt_d  = 16'h0;
                    if (hitRam) begin
                        slave_d = SLV_RAM;
                        state_d = ACCESS;
                    end else if (hitLeds) begin
                        slave_d = SLV_LEDS;
                        state_d = ACCESS;
                    end else begin
                        slave_d   = SLV_NONE;
                        state_d   = RESP;
                        rdata_d   = ERR_DATA;
                        errSet    = 1'b1;
                        errAddr_d = mem_addr;
                    end
                end
            end

            ACCESS: begin
                if (slaveReady) begin
                    rdata_d = (reqWstrb_q != 4'b0000) ? 32'h0 : slaveRdata;
                    state_d = RESP;
                end else if (waitCnt_q == TIMEOUT_W) begin
                    rdata_d   = ERR_DATA;
                    errSet    = 1'b1;
                    errAddr_d = reqAddr_q;
                    state_d   = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end

            RESP: begin
                slave_d = SLV_NONE;
                state_d = IDLE;
            end

            default: begin
                slave_d = SLV_NONE;
                state_d = IDLE;
            end
        endcase

        if (errSet) begin
            busErr_d = 1'b1;
        end
    end

    // State and datapath registers. Reset aborts any transaction in flight
    // without producing a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            slave_q    <= SLV_NONE;
            reqAddr_q  <= 32'h0;
            reqWdata_q <= 32'h0;
            reqWstrb_q <= 4'b0000;
            waitCnt_q  <= 16'h0;
            rdata_q    <= 32'h0;
            busErr_q   <= 1'b0;
            errAddr_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            slave_q    <= slave_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            reqWstrb_q <= reqWstrb_d;
            waitCnt_q  <= waitCnt_d;
            rdata_q    <= rdata_d;
            busErr_q   <= busErr_d;
            errAddr_q  <= errAddr_d;
        end
    end

endmodule

// File: tb/tb_pico_bus_decoder.sv
// tb_pico_bus_decoder
// Bench for pico_bus_decoder. Transactions are described by address, strobes,
// slave wait count and slave data. The expected latency, data and error state
// follow from the address map and the cycle budget, worked out with plain
// arithmetic on each transaction.

module tb_pico_bus_decoder;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam int          RAM_AW    = 14;
    localparam logic [31:0] LEDS_ADDR = 32'h1000_0000;
    localparam int          TIMEOUT   = 255;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        ram_sel;
    logic        ram_ready;
    logic [31:0] ram_rdata;
    logic        leds_sel;
    logic        leds_ready;
    logic [31:0] leds_rdata;
    logic        slv_we;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        bus_err_clr;
    logic        bus_err;
    logic [31:0] err_addr;

    int          checkCount = 0;
    int          errorCount = 0;

    logic        modelErr     = 1'b0;
    logic [31:0] modelErrAddr = 32'h0;
    logic [31:0] lastData     = 32'h0;

    pico_bus_decoder #(
        .RAM_BASE  (RAM_BASE),
        .RAM_AW    (RAM_AW),
        .LEDS_ADDR (LEDS_ADDR),
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (ERR_DATA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .ram_sel     (ram_sel),
        .ram_ready   (ram_ready),
        .ram_rdata   (ram_rdata),
        .leds_sel    (leds_sel),
        .leds_ready  (leds_ready),
        .leds_rdata  (leds_rdata),
        .slv_we      (slv_we),
        .slv_wdata   (slv_wdata),
        .slv_wstrb   (slv_wstrb),
        .bus_err_clr (bus_err_clr),
        .bus_err     (bus_err),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit isRamAddr(input logic [31:0] a);
        longint unsigned lo;
        longint unsigned hi;
        lo = longint'(RAM_BASE);
        hi = lo + (64'd1 << RAM_AW);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic bit isLedsAddr(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) == LEDS_ADDR;
    endfunction

    // One complete core transaction. Cycle 0 is the cycle in which mem_valid
    // is first sampled; the response is expected at cycle expLat.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb, input int waits,
                                 input logic [31:0] slaveData, input bit dropValid, input bit clrPulse);
        int          kind;
        int          expLat;
        bit          isErr;
        bit          active;
        logic [31:0] expData;
        logic [31:0] wdata;

        kind    = isRamAddr(addr) ? 0 : (isLedsAddr(addr) ? 1 : 2);
        isErr   = (kind == 2) || (waits > TIMEOUT);
        expLat  = (kind == 2) ? 1 : 2 + ((waits > TIMEOUT) ? TIMEOUT : waits);
        expData = isErr ? ERR_DATA : ((wstrb != 4'b0000) ? 32'h0 : slaveData);
        wdata   = $urandom;

        @(posedge clk); #1;
        checkOutput("idle_ready", mem_ready, 1'b0);
        checkOutput("idle_rdata", mem_rdata, lastData);
        checkOutput("idle_ramsel", ram_sel, 1'b0);
        checkOutput("idle_ledsel", leds_sel, 1'b0);
        mem_valid   = 1'b1;
        mem_addr    = addr;
        mem_wdata   = wdata;
        mem_wstrb   = wstrb;
        ram_rdata   = (kind == 0) ? slaveData : $urandom;
        leds_rdata  = (kind == 1) ? slaveData : $urandom;
        ram_ready   = 1'($urandom_range(0, 1));
        leds_ready  = 1'($urandom_range(0, 1));
        bus_err_clr = clrPulse && (expLat == 1);

        for (int cyc = 1; cyc <= expLat; cyc++) begin
            @(posedge clk); #1;
            if (dropValid) mem_valid = 1'b0;
            bus_err_clr = clrPulse && (cyc == expLat - 1);
            ram_ready   = (kind == 0) ? (cyc == 1 + waits) : 1'($urandom_range(0, 1));
            leds_ready  = (kind == 1) ? (cyc == 1 + waits) : 1'($urandom_range(0, 1));
            active      = (cyc < expLat) && (kind != 2);

            checkOutput("ready", mem_ready, (cyc == expLat));
            checkOutput("ram_sel", ram_sel, active && (kind == 0));
            checkOutput("leds_sel", leds_sel, active && (kind == 1));
            checkOutput("slv_we", slv_we, active && (wstrb != 4'b0000));
            if (active) begin
                checkOutput("slv_wdata", slv_wdata, wdata);
                checkOutput("slv_wstrb", {28'h0, slv_wstrb}, {28'h0, wstrb});
            end

            if (cyc == expLat) begin
                mem_valid = 1'b0;
                if (isErr) begin
                    modelErr     = 1'b1;
                    modelErrAddr = addr;
                end else if (clrPulse) begin
                    modelErr = 1'b0;
                end
                lastData = expData;
                checkOutput("rdata", mem_rdata, expData);
                checkOutput("bus_err", bus_err, modelErr);
                checkOutput("err_addr", err_addr, modelErrAddr);
            end
        end
        bus_err_clr = 1'b0;
    endtask

    task automatic clearErr();
        @(posedge clk); #1;
        bus_err_clr = 1'b1;
        @(posedge clk); #1;
        bus_err_clr = 1'b0;
        modelErr = 1'b0;
        checkOutput("clr_bus_err", bus_err, 1'b0);
        checkOutput("clr_err_addr", err_addr, modelErrAddr);
    endtask

    task automatic resetMidAccess();
        @(posedge clk); #1;
        mem_valid  = 1'b1;
        mem_addr   = 32'h0000_0200;
        mem_wstrb  = 4'b0000;
        ram_ready  = 1'b0;
        leds_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pre_ramsel", ram_sel, 1'b1);
        reset     = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        reset        = 1'b0;
        modelErr     = 1'b0;
        modelErrAddr = 32'h0;
        lastData     = 32'h0;
        checkOutput("rst_ramsel", ram_sel, 1'b0);
        checkOutput("rst_ledsel", leds_sel, 1'b0);
        checkOutput("rst_bus_err", bus_err, 1'b0);
        checkOutput("rst_err_addr", err_addr, 32'h0);
        checkOutput("rst_rdata", mem_rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ram_ready = 1'b1;
            checkOutput("rst_no_ready", mem_ready, 1'b0);
            @(posedge clk); #1;
        end
        ram_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;

        reset       = 1'b1;
        mem_valid   = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_wstrb   = 4'b0000;
        ram_ready   = 1'b0;
        ram_rdata   = 32'h0;
        leds_ready  = 1'b0;
        leds_rdata  = 32'h0;
        bus_err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_ready", mem_ready, 1'b0);
        checkOutput("reset_rdata", mem_rdata, 32'h0);
        checkOutput("reset_ramsel", ram_sel, 1'b0);
        checkOutput("reset_ledsel", leds_sel, 1'b0);
        checkOutput("reset_bus_err", bus_err, 1'b0);
        checkOutput("reset_err_addr", err_addr, 32'h0);

        // Directed cases from the address map and latency rules
        applyStimulus(LEDS_ADDR, 4'b0001, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(LEDS_ADDR, 4'b0000, 0, 32'h0000_0015, 1'b0, 1'b0);
        applyStimulus(32'h0000_0100, 4'b0000, 3, 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(32'h2000_0000, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
        clearErr();
        applyStimulus(32'h0000_0040, 4'b0000, TIMEOUT + 1, 32'h0BAD_F00D, 1'b0, 1'b0);
        clearErr();
        applyStimulus(32'h0000_3FFC, 4'b0000, TIMEOUT, 32'hCAFE_0001, 1'b0, 1'b0);
        applyStimulus(32'h0000_4000, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
        resetMidAccess();
        applyStimulus(LEDS_ADDR + 32'd3, 4'b1111, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(LEDS_ADDR + 32'd4, 4'b0000, 0, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h0000_0010, 4'b0000, 2, 32'hA5A5_5A5A, 1'b1, 1'b0);

        // Randomized traffic across RAM, LEDs and unmapped space
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0: a = RAM_BASE + 32'($urandom_range(0, (1 << RAM_AW) - 1));
                1: a = LEDS_ADDR + 32'($urandom_range(0, 3));
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = RAM_BASE + 32'(1 << RAM_AW) + 32'($urandom_range(0, 255));
                        1:       a = LEDS_ADDR + 32'd4;
                        2:       a = LEDS_ADDR - 32'd4;
                        default: a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
                    endcase
                end
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            applyStimulus(a, ws, $urandom_range(0, 5), $urandom,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
